// File: rtl/rv_mem_arbiter_if.sv
// CPU fetch/data ports plus the shared single-ported memory bus.
// The master modport is the arbiter's view; slave is the CPU/memory side.
interface rv_mem_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  im_req_i;
   logic [31:0]           im_addr_i;
   logic                  im_kill_i;
   logic [31:0]           im_data_o;
   logic                  im_valid_o;
   logic [31:0]           dm_addr_i;
   logic [31:0]           dm_data_s_i;
   logic [3:0]            dm_data_select_i;
   logic                  dm_load_i;
   logic                  dm_store_i;
   logic                  dm_ready_o;
   logic [31:0]           dm_data_l_o;
   logic                  dm_load_done_o;
   logic                  dm_store_done_o;
   logic                  mem_req_o;
   logic                  mem_we_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [31:0]           mem_wdata_o;
   logic [3:0]            mem_sel_o;
   logic                  mem_ack_i;
   logic [31:0]           mem_rdata_i;

   modport master (
      input  im_req_i, im_addr_i, im_kill_i,
      input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_load_i, dm_store_i,
      input  mem_ack_i, mem_rdata_i,
      output im_data_o, im_valid_o,
      output dm_ready_o, dm_data_l_o, dm_load_done_o, dm_store_done_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o
   );

   modport slave (
      output im_req_i, im_addr_i, im_kill_i,
      output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_load_i, dm_store_i,
      output mem_ack_i, mem_rdata_i,
      input  im_data_o, im_valid_o,
      input  dm_ready_o, dm_data_l_o, dm_load_done_o, dm_store_done_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o
   );
endinterface

// File: rtl/rv_mem_arbiter.sv
// Data-priority arbiter sharing one memory bus between fetch and load/store,
// with a starvation cap on consecutive data grants and fetch kill support.
module rv_mem_arbiter #(
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned MAX_DM_STREAK = 4
) (
   input logic               clk_i,
   input logic               rst_i,
   rv_mem_arbiter_if.master  bus
);
   localparam int unsigned STREAK_W = 4;
   localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_DM_STREAK);

   typedef enum logic [1:0] {IDLE, BUS_IM, BUS_DM_RD, BUS_DM_WR} state_t;

   state_t                state, state_d;
   logic                  settle, settle_d;
   logic                  kill, kill_d;
   logic [STREAK_W-1:0]   streak, streak_d;
   logic                  dm_ready, dm_ready_d;
   logic                  hold_we, hold_we_d;
   logic [31:0]           hold_addr, hold_addr_d;
   logic [31:0]           hold_wdata, hold_wdata_d;
   logic [3:0]            hold_sel, hold_sel_d;
   logic                  mem_req, mem_req_d;
   logic                  mem_we, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr, mem_addr_d;
   logic [31:0]           mem_wdata, mem_wdata_d;
   logic [3:0]            mem_sel, mem_sel_d;
   logic                  im_valid, im_valid_d;
   logic [31:0]           im_data, im_data_d;
   logic                  load_done, load_done_d;
   logic                  store_done, store_done_d;
   logic [31:0]           dm_data_l, dm_data_l_d;

   logic                  accept, dm_pending, pend_we;
   logic [31:0]           pend_addr, pend_wdata;
   logic [3:0]            pend_sel;

   // A request arriving this cycle competes immediately, so simultaneous
   // fetch and data requests resolve in favour of data.
   always_comb begin
      accept     = dm_ready & (bus.dm_load_i | bus.dm_store_i);
      dm_pending = ~dm_ready | accept;
      pend_we    = accept ? bus.dm_store_i       : hold_we;
      pend_addr  = accept ? bus.dm_addr_i        : hold_addr;
      pend_wdata = accept ? bus.dm_data_s_i      : hold_wdata;
      pend_sel   = accept ? bus.dm_data_select_i : hold_sel;
   end

   always_comb begin
      state_d      = state;
      settle_d     = 1'b0;
      kill_d       = kill;
      streak_d     = streak;
      dm_ready_d   = dm_ready;
      hold_we_d    = hold_we;
      hold_addr_d  = hold_addr;
      hold_wdata_d = hold_wdata;
      hold_sel_d   = hold_sel;
      mem_req_d    = mem_req;
      mem_we_d     = mem_we;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;
      mem_sel_d    = mem_sel;
      im_valid_d   = 1'b0;
      im_data_d    = im_data;
      load_done_d  = 1'b0;
      store_done_d = 1'b0;
      dm_data_l_d  = dm_data_l;

      if (accept) begin
         dm_ready_d   = 1'b0;
         hold_we_d    = bus.dm_store_i;
         hold_addr_d  = bus.dm_addr_i;
         hold_wdata_d = bus.dm_data_s_i;
         hold_sel_d   = bus.dm_data_select_i;
      end

      case (state)
         IDLE: begin
            // The cycle after a completion is skipped so a level fetch request
            // still high alongside im_valid_o is not granted twice.
            if (!settle) begin
               if (dm_pending && (!bus.im_req_i || streak < MAX_S)) begin
                  state_d     = pend_we ? BUS_DM_WR : BUS_DM_RD;
                  mem_req_d   = 1'b1;
                  mem_we_d    = pend_we;
                  mem_addr_d  = ADDR_WIDTH'(pend_addr);
                  mem_wdata_d = pend_wdata;
                  mem_sel_d   = pend_we ? pend_sel : 4'hF;
                  if (bus.im_req_i)
                     streak_d = (streak >= MAX_S) ? MAX_S : streak + STREAK_W'(1);
                  else
                     streak_d = '0;
               end else if (bus.im_req_i && !bus.im_kill_i) begin
                  state_d    = BUS_IM;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = ADDR_WIDTH'(bus.im_addr_i);
                  mem_sel_d  = 4'hF;
                  streak_d   = '0;
                  kill_d     = 1'b0;
               end
            end
         end
         BUS_IM: begin
            kill_d = kill | bus.im_kill_i;
            if (bus.mem_ack_i) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               settle_d  = 1'b1;
               kill_d    = 1'b0;
               if (!(kill | bus.im_kill_i)) begin
                  im_valid_d = 1'b1;
                  im_data_d  = bus.mem_rdata_i;
               end
            end
         end
         BUS_DM_RD: begin
            if (bus.mem_ack_i) begin
               state_d     = IDLE;
               mem_req_d   = 1'b0;
               settle_d    = 1'b1;
               load_done_d = 1'b1;
               dm_data_l_d = bus.mem_rdata_i;
               dm_ready_d  = 1'b1;
            end
         end
         BUS_DM_WR: begin
            if (bus.mem_ack_i) begin
               state_d      = IDLE;
               mem_req_d    = 1'b0;
               settle_d     = 1'b1;
               store_done_d = 1'b1;
               dm_ready_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         settle     <= 1'b0;
         kill       <= 1'b0;
         streak     <= '0;
         dm_ready   <= 1'b1;
         hold_we    <= 1'b0;
         hold_addr  <= '0;
         hold_wdata <= '0;
         hold_sel   <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_sel    <= '0;
         im_valid   <= 1'b0;
         im_data    <= '0;
         load_done  <= 1'b0;
         store_done <= 1'b0;
         dm_data_l  <= '0;
      end else begin
         state      <= state_d;
         settle     <= settle_d;
         kill       <= kill_d;
         streak     <= streak_d;
         dm_ready   <= dm_ready_d;
         hold_we    <= hold_we_d;
         hold_addr  <= hold_addr_d;
         hold_wdata <= hold_wdata_d;
         hold_sel   <= hold_sel_d;
         mem_req    <= mem_req_d;
         mem_we     <= mem_we_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
         mem_sel    <= mem_sel_d;
         im_valid   <= im_valid_d;
         im_data    <= im_data_d;
         load_done  <= load_done_d;
         store_done <= store_done_d;
         dm_data_l  <= dm_data_l_d;
      end
   end

   assign bus.im_valid_o      = im_valid;
   assign bus.im_data_o       = im_data;
   assign bus.dm_ready_o      = dm_ready;
   assign bus.dm_data_l_o     = dm_data_l;
   assign bus.dm_load_done_o  = load_done;
   assign bus.dm_store_done_o = store_done;
   assign bus.mem_req_o       = mem_req;
   assign bus.mem_we_o        = mem_we;
   assign bus.mem_addr_o      = mem_addr;
   assign bus.mem_wdata_o     = mem_wdata;
   assign bus.mem_sel_o       = mem_sel;
endmodule
